// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM state encoding,
// Booth recoding operations and the default operand width.
package booth_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // Radix-2 recoding of the pair {q[0], q[-1]}.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Request/result bundle of booth_seq_multiplier; master issues operands, slave
// returns busy/done and the 2N-bit product.
interface booth_seq_multiplier_if #(parameter int N = booth_pkg::N_DEFAULT);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (output start, multiplicand, multiplier,
                  input  busy, done, product);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, product);
endinterface

// File: rtl/twos_adder.sv
// W-bit two's-complement adder/subtractor: c_in=0 gives a+b, c_in=1 gives a-b.
module twos_adder #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  logic [W-1:0] b_eff;

  assign b_eff        = b ^ {W{c_in}};
  assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_in};
endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one recoding step per clock.
// Optional zero-operand / drained-multiplier shortcut: BOOTH_SEQ_EARLY_DONE_EN.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic                   clk,
  input logic                   rst_n,
  booth_seq_multiplier_if.slave bus
);
  localparam int CNT_W = $clog2(N + 1);

  state_t           state_q, state_d;
  logic [N:0]       acc_q, acc_d;
  logic [N:0]       m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             done_q, done_d;

  booth_op_t  op;
  logic       c_in;
  logic [N:0] sum;
  logic [N:0] acc_step;
  logic       adder_c_out_unused;

  assign op       = booth_decode(q_q[0], qm1_q);
  assign c_in     = (op == BOOTH_SUB);
  assign acc_step = (op == BOOTH_NOP) ? acc_q : sum;

  twos_adder #(.W(N + 1)) u_adder (
    .a     (acc_q),
    .b     (m_q),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (adder_c_out_unused)
  );

`ifdef BOOTH_SEQ_EARLY_DONE_EN
  // With the multiplier fully consumed, the remaining steps are pure sign-fill shifts.
  logic [2*N:0] drained;
  assign drained = $signed({acc_q, q_q}) >>> cnt_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          m_d     = {bus.multiplicand[N-1], bus.multiplicand};
          cnt_d   = CNT_W'(N);
          state_d = RUN;
`ifdef BOOTH_SEQ_EARLY_DONE_EN
          if (bus.multiplicand == '0 || bus.multiplier == '0) begin
            q_d     = '0;
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end

      RUN: begin
`ifdef BOOTH_SEQ_EARLY_DONE_EN
        if (q_q == '0 && !qm1_q) begin
          acc_d   = drained[2*N:N];
          q_d     = drained[N-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
`endif
          acc_d = {acc_step[N], acc_step[N:1]};
          q_d   = {acc_step[0], q_q[N-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
`ifdef BOOTH_SEQ_EARLY_DONE_EN
        end
`endif
      end

      DONE: begin
        product_d = {acc_q[N-1:0], q_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule
